// File: rtl/adc_serial_reader.sv
// CNV/SCK serial ADC readout with 2^AVG_LOG2 averaging and
// saturating gain around midscale, feeding the loop DAC driver.
module adc_serial_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int CNV_CYCLES    = 15,
  parameter int SCK_DIV       = 1,
  parameter int AVG_LOG2      = 0,
  parameter int SAMPLE_PERIOD = 64
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [3:0]            gain_shift,
  input  logic                  sdo,
  output logic                  cnv,
  output logic                  sck,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic [DATA_WIDTH-1:0] amplified_data,
  output logic                  data_valid,
  output logic                  saturated,
  output logic                  busy
);

  localparam int W   = DATA_WIDTH;
  localparam int CW  = $clog2(SAMPLE_PERIOD + 1);
  localparam int PW  = $clog2(SCK_DIV + 1);
  localparam int BW  = $clog2(W + 1);
  localparam int SW  = AVG_LOG2 + 1;
  localparam int ACW = W + AVG_LOG2;
  localparam int AW  = W + 17;

  localparam logic [CW-1:0] CNV_LAST = CW'(CNV_CYCLES - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PH_LAST  = PW'(SCK_DIV - 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [SW-1:0] SMP_FULL = SW'(1 << AVG_LOG2);
  localparam logic [SW-1:0] SMP_ONE  = SW'(1);

  localparam logic signed [AW-1:0] MID =
    {{17{1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] MAXV =
    {{17{1'b0}}, {W{1'b1}}};

  if (SAMPLE_PERIOD < CNV_CYCLES + 2*SCK_DIV*W + 2)
  begin : g_bad_period
    $error("SAMPLE_PERIOD too short for frame");
  end
  if (SCK_DIV < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4)
  begin : g_bad_param
    $error("SCK_DIV or AVG_LOG2 out of range");
  end

  typedef enum logic [2:0] {
    IDLE, CONV, READ, DONE, WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ph;
  logic [BW-1:0]   bit_cnt;
  logic [W-1:0]    shreg;
  logic [ACW-1:0]  acc;
  logic [SW-1:0]   smp_cnt;

  logic [ACW-1:0]        acc_next;
  logic [SW-1:0]         smp_next;
  logic [W-1:0]          avg;
  logic signed [AW-1:0]  dev;
  logic signed [AW-1:0]  amp_full;
  logic [W-1:0]          amp_clamp;
  logic                  sat_next;

  always_comb begin
    acc_next  = acc + ACW'(shreg);
    smp_next  = smp_cnt + SMP_ONE;
    avg       = acc_next[ACW-1:AVG_LOG2];
    dev       = $signed(AW'(avg)) - MID;
    amp_full  = (dev <<< gain_shift) + MID;
    amp_clamp = amp_full[W-1:0];
    sat_next  = 1'b0;
    if (amp_full > MAXV) begin
      amp_clamp = '1;
      sat_next  = 1'b1;
    end else if (amp_full[AW-1]) begin
      amp_clamp = '0;
      sat_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      cnt            <= '0;
      ph             <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      acc            <= '0;
      smp_cnt        <= '0;
      cnv            <= 1'b0;
      sck            <= 1'b0;
      raw_data       <= '0;
      amplified_data <= '0;
      data_valid     <= 1'b0;
      saturated      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      cnt        <= cnt + CNT_ONE;
      unique case (state)
        IDLE: if (enable) begin
          state <= CONV;
          cnv   <= 1'b1;
          busy  <= 1'b1;
          cnt   <= '0;
        end
        CONV: if (cnt == CNV_LAST) begin
          state   <= READ;
          cnv     <= 1'b0;
          sck     <= 1'b1;
          ph      <= '0;
          bit_cnt <= '0;
        end
        READ: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            // sample at the end of the high phase, ADC shifts on fall
            if (sck) begin
              shreg <= {shreg[W-2:0], sdo};
              sck   <= 1'b0;
            end else if (bit_cnt == BIT_LAST) begin
              state <= DONE;
            end else begin
              sck     <= 1'b1;
              bit_cnt <= bit_cnt + BIT_ONE;
            end
          end else begin
            ph <= ph + PH_ONE;
          end
        end
        DONE: begin
          state   <= WAIT;
          acc     <= acc_next;
          smp_cnt <= smp_next;
          if (smp_next == SMP_FULL) begin
            acc            <= '0;
            smp_cnt        <= '0;
            raw_data       <= avg;
            amplified_data <= amp_clamp;
            saturated      <= sat_next;
            data_valid     <= 1'b1;
          end
        end
        WAIT: if (cnt == PER_LAST) begin
          if (enable) begin
            state <= CONV;
            cnv   <= 1'b1;
            cnt   <= '0;
          end else begin
            // a partial average group is dropped
            state   <= IDLE;
            busy    <= 1'b0;
            acc     <= '0;
            smp_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
